// File: rtl/tdm_demux4.sv
// Time-division 1:4 demultiplexer: slots 0..3 of a word-serial frame go to a..d,
// with start-of-frame alignment, re-sync on an early sof, and atomic frame output.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  // Slot 3 never needs a shadow: it is written straight into d on completion.
  logic [WIDTH-1:0] shadow_q [3];
  logic [WIDTH-1:0] shadow_d [3];
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sof) begin
            shadow_d[0] = din;
            sel_d       = 2'd1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (sof) begin
            // An sof mid-frame drops the partial frame and restarts at slot 0.
            shadow_d[0] = din;
            sel_d       = 2'd1;
            sync_err_d  = (sel_q != 2'd0);
          end else if (sel_q == 2'd3) begin
            a_d           = shadow_q[0];
            b_d           = shadow_q[1];
            c_d           = shadow_q[2];
            d_d           = din;
            frame_valid_d = 1'b1;
            sel_d         = 2'd0;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (sel_q == 2'(i)) shadow_d[i] = din;
            end
            sel_d = sel_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      sel_q         <= 2'd0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      for (int i = 0; i < 3; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign sel         = sel_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == RUN);

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division 1:4 demultiplexer. It takes one word-serial stream in which each frame carries four channel words (slot 0..3), and distributes the words back to four parallel channel outputs a, b, c, d.
- It is the receive-side counterpart of the codebase's 4:1 select mux: slot index here plays the role of `sel` there (slot 0 -> a, 1 -> b, 2 -> c, 3 -> d).
- It tracks frame alignment with a start-of-frame marker and presents each completed frame atomically.

Parameters:
- WIDTH, 1: width of each channel word and of the input stream.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  serial stream word.
- din_valid  input  1  din carries a word this cycle.
- sof  input  1  start of frame; valid only with din_valid=1; marks din as slot 0.
- a  output  WIDTH  channel 0 word of the last completed frame.
- b  output  WIDTH  channel 1 word of the last completed frame.
- c  output  WIDTH  channel 2 word of the last completed frame.
- d  output  WIDTH  channel 3 word of the last completed frame.
- sel  output  2  slot index the next accepted word will fill.
- frame_valid  output  1  one-cycle pulse: a..d were just updated.
- sync_err  output  1  one-cycle pulse: partial frame discarded on re-sync.
- locked  output  1  high while in RUN state.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - a, b, c, d, shadow registers, sel: 0.
  - frame_valid, sync_err, locked: 0.
  - state: HUNT.
  - Takes effect immediately, mid-frame included; any partial frame is lost with no pulse.
- Word acceptance:
  - A word is accepted when din_valid=1.
  - din_valid=0: no state change; sel holds (gaps allowed anywhere in a frame).
  - sof with din_valid=0 is ignored.
- State HUNT:
  - Accepted words without sof are discarded.
  - Accepted word with sof: store to shadow slot 0, sel<=1, go to RUN, locked<=1.
- State RUN:
  - Accepted word without sof is stored to shadow[sel], sel<=sel+1 (2-bit wrap, 3 -> 0).
  - When the stored slot is 3:
    - next cycle a=shadow0, b=shadow1, c=shadow2, d=din (slot-3 word), all updated together;
    - frame_valid=1 for that one cycle.
  - Latency: 1 clock from the accepting edge of slot 3 to a..d/frame_valid visible.
  - a..d hold their value between frames.
  - sof while sel=0 is a normal frame start.
  - Back-to-back frames: the slot-3 word followed immediately by the next sof with no gap is legal. No word is lost and frame_valid pulses once per frame.
- Re-sync:
  - sof accepted in RUN with sel!=0: discard shadows for the current partial frame.
  - Store din as slot 0, sel<=1, sync_err=1 for one cycle.
  - a..d unchanged; no frame_valid.
- Missing sof: RUN never requires sof after the first one. Frames continue by counting; sel wrapping 3 -> 0 is the frame boundary.
- sync_err and frame_valid are never both high: re-sync implies slot 0 is being written, so no completion occurs that cycle.
- Registers: all outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic frame: WIDTH=4, reset, then sof+din=1, din=2, din=3, din=4 on consecutive cycles -> one cycle after din=4: a=1, b=2, c=3, d=4, frame_valid=1 for exactly one cycle, sel=0, locked=1.
- Hunt and gaps: din=9, 9 without sof -> a..d stay 0, locked=0. Then sof+5, idle cycle, 6, idle ×2, 7, 8 -> a=5, b=6, c=7, d=8; sel holds during idle cycles.
- Back-to-back plus wrap: two frames 1..4 then A..D with no gap, second without sof -> frame_valid pulses twice; after the second, a=A, b=B, c=C, d=D.
- Re-sync: after a good frame, sof+1, 2, then sof+E, F, 0, 1 -> sync_err one cycle on the second sof, no frame_valid for the partial frame; then a=E, b=F, c=0, d=1.
- Reset mid-frame: sof+3, 4, assert rst_n=0 between clock edges -> outputs 0 immediately, no pulses. After release, words without sof are ignored until the next sof.
- Randomised bench: random din_valid gaps plus random sof injection, compared against a reference model over 1000 frames -> exact match on a..d, frame_valid, sync_err.
